// File: rtl/exec_pkg.sv
// exec_pkg: shared constants and types for the exec_sequencer slice.
//   DATA_W / NUM_REGS / REG_ADDR_W  : datapath width, register count, register address width
//   *_HI / *_LO                     : bit positions of the instruction fields
//   opcode_e                        : the eleven supported opcodes
//   seq_state_e                     : sequencer states IDLE -> READ -> EXEC -> WB
//   isLegalOp()                     : true for any opcode the ALU implements
package exec_pkg;

    localparam int DATA_W     = 16;
    localparam int NUM_REGS   = 8;
    localparam int REG_ADDR_W = 3;

    localparam int OPC_HI = 15;
    localparam int OPC_LO = 12;
    localparam int RD_HI  = 11;
    localparam int RD_LO  = 9;
    localparam int RS1_HI = 8;
    localparam int RS1_LO = 6;
    localparam int RS2_HI = 5;
    localparam int RS2_LO = 3;
    localparam int IMM_HI = 5;
    localparam int IMM_LO = 0;

    typedef enum logic [3:0] {
        OP_ADDI = 4'b0001,
        OP_ADD  = 4'b0011,
        OP_SUB  = 4'b1011,
        OP_AND  = 4'b0101,
        OP_OR   = 4'b1101,
        OP_XOR  = 4'b1111,
        OP_NOT  = 4'b0111,
        OP_SLL  = 4'b0110,
        OP_SRL  = 4'b0100,
        OP_SLLI = 4'b1110,
        OP_SRLI = 4'b1100
    } opcode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        EXEC = 2'd2,
        WB   = 2'd3
    } seq_state_e;

    // LOAD (0010), STORE (1010) and every unlisted encoding are rejected.
    function automatic logic isLegalOp(input logic [3:0] op);
        case (op)
            OP_ADDI, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
            OP_NOT, OP_SLL, OP_SRL, OP_SLLI, OP_SRLI: return 1'b1;
            default:                                  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/exec_alu.sv
// exec_alu: purely combinational 16-bit ALU used in the EXEC state.
//   opcode_i : 4-bit opcode from the instruction register
//   opA_i    : first operand (rf[rs1])
//   opB_i    : second operand (rf[rs2]); also the shift amount for SLL/SRL
//   imm_i    : 6-bit immediate, zero-extended; shift amount for SLLI/SRLI
//   result_o : ALU result, modulo 2^16; 0 for unsupported opcodes
module exec_alu
    import exec_pkg::*;
(
    input  logic [3:0]        opcode_i,
    input  logic [DATA_W-1:0] opA_i,
    input  logic [DATA_W-1:0] opB_i,
    input  logic [5:0]        imm_i,
    output logic [DATA_W-1:0] result_o
);

    logic [DATA_W-1:0] immExt;

    // Any set bit at or above bit 4 means the amount is 16 or more, which
    // shifts every data bit out.
    function automatic logic [DATA_W-1:0] shiftLeft(input logic [DATA_W-1:0] v,
                                                    input logic [DATA_W-1:0] amt);
        if (|amt[DATA_W-1:4]) return '0;
        return v << amt[3:0];
    endfunction

    function automatic logic [DATA_W-1:0] shiftRight(input logic [DATA_W-1:0] v,
                                                     input logic [DATA_W-1:0] amt);
        if (|amt[DATA_W-1:4]) return '0;
        return v >> amt[3:0];
    endfunction

    // Opcode decode; carries and borrows fall off the top of the 16-bit result.
    always_comb begin
        immExt   = {{(DATA_W-6){1'b0}}, imm_i};
        result_o = '0;
        case (opcode_i)
            OP_ADDI: result_o = opA_i + immExt;
            OP_ADD:  result_o = opA_i + opB_i;
            OP_SUB:  result_o = opA_i - opB_i;
            OP_AND:  result_o = opA_i & opB_i;
            OP_OR:   result_o = opA_i | opB_i;
            OP_XOR:  result_o = opA_i ^ opB_i;
            OP_NOT:  result_o = ~opA_i;
            OP_SLL:  result_o = shiftLeft(opA_i, opB_i);
            OP_SRL:  result_o = shiftRight(opA_i, opB_i);
            OP_SLLI: result_o = shiftLeft(opA_i, immExt);
            OP_SRLI: result_o = shiftRight(opA_i, immExt);
            default: result_o = '0;
        endcase
    end

endmodule

// File: rtl/exec_sequencer.sv
// exec_sequencer: multi-cycle instruction sequencer owning the 8 x 16-bit
// register file; each instruction walks IDLE -> READ -> EXEC -> WB.
//   clk, arst          : clock (rising edge), asynchronous active-high reset
//   instr_valid/_ready : instruction handshake; ready only in IDLE with no flush
//   instr              : [15:12] opcode, [11:9] rd, [8:6] rs1, [5:3] rs2, [5:0] imm
//   flush              : aborts an instruction in READ or EXEC, ignored in WB
//   wb_valid/addr/data : registered one-cycle writeback indication (WB state)
//   illegal            : registered one-cycle pulse during READ of a bad opcode
//   dbg_addr/dbg_data  : combinational register file read port
// Optional feature, enabled by defining EXEC_SEQ_PERF_CNT_EN:
//   retired_cnt (32b) counts wb_valid pulses, illegal_cnt (16b) counts illegal pulses.
module exec_sequencer
    import exec_pkg::*;
(
    input  logic                  clk,
    input  logic                  arst,
    input  logic                  instr_valid,
    output logic                  instr_ready,
    input  logic [DATA_W-1:0]     instr,
    input  logic                  flush,
    output logic                  wb_valid,
    output logic [REG_ADDR_W-1:0] wb_addr,
    output logic [DATA_W-1:0]     wb_data,
    output logic                  illegal,
    input  logic [REG_ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0]     dbg_data
`ifdef EXEC_SEQ_PERF_CNT_EN
    ,
    output logic [31:0]           retired_cnt,
    output logic [15:0]           illegal_cnt
`endif
);

    seq_state_e            state_q, state_d;
    logic [DATA_W-1:0]     rf_q [NUM_REGS];
    logic [DATA_W-1:0]     ir_q;
    logic [DATA_W-1:0]     opA_q, opB_q, result_q;
    logic [DATA_W-1:0]     wbData_q;
    logic [REG_ADDR_W-1:0] wbAddr_q;
    logic                  wbValid_q, illegal_q;
    logic [DATA_W-1:0]     aluResult;
    logic                  accept;

    logic [3:0]            irOpcode;
    logic [REG_ADDR_W-1:0] irRd, irRs1, irRs2;

    assign irOpcode = ir_q[OPC_HI:OPC_LO];
    assign irRd     = ir_q[RD_HI:RD_LO];
    assign irRs1    = ir_q[RS1_HI:RS1_LO];
    assign irRs2    = ir_q[RS2_HI:RS2_LO];

    assign instr_ready = (state_q == IDLE) && !flush;
    assign accept      = instr_valid && instr_ready;

    assign wb_valid = wbValid_q;
    assign wb_addr  = wbAddr_q;
    assign wb_data  = wbData_q;
    assign illegal  = illegal_q;
    assign dbg_data = rf_q[dbg_addr];

    exec_alu u_alu (
        .opcode_i (irOpcode),
        .opA_i    (opA_q),
        .opB_i    (opB_q),
        .imm_i    (ir_q[IMM_HI:IMM_LO]),
        .result_o (aluResult)
    );

    // Next-state selection. A bad opcode leaves READ straight for IDLE; a
    // flush aborts READ and EXEC but cannot stop a WB that is already under way.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = READ;
            READ: state_d = (!isLegalOp(irOpcode) || flush) ? IDLE : EXEC;
            EXEC: state_d = flush ? IDLE : WB;
            WB:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Sequencer registers, register file and registered outputs. The illegal
    // pulse is registered at the accept edge so it is visible during READ.
    // The wb_* outputs are loaded on the EXEC->WB edge so they are visible
    // throughout WB, and the register file commits on the edge leaving WB.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q   <= IDLE;
            ir_q      <= '0;
            opA_q     <= '0;
            opB_q     <= '0;
            result_q  <= '0;
            wbValid_q <= 1'b0;
            wbAddr_q  <= '0;
            wbData_q  <= '0;
            illegal_q <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) rf_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            wbValid_q <= 1'b0;
            illegal_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        ir_q      <= instr;
                        illegal_q <= !isLegalOp(instr[OPC_HI:OPC_LO]);
                    end
                end
                READ: begin
                    opA_q <= rf_q[irRs1];
                    opB_q <= rf_q[irRs2];
                end
                EXEC: begin
                    result_q <= aluResult;
                    if (!flush) begin
                        wbValid_q <= 1'b1;
                        wbAddr_q  <= irRd;
                        wbData_q  <= aluResult;
                    end
                end
                WB: rf_q[wbAddr_q] <= result_q;
                default: ;
            endcase
        end
    end

`ifdef EXEC_SEQ_PERF_CNT_EN
    logic [31:0] retiredCnt_q;
    logic [15:0] illegalCnt_q;

    // Event counters driven from the registered pulses; both wrap naturally.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            retiredCnt_q <= '0;
            illegalCnt_q <= '0;
        end else begin
            if (wbValid_q) retiredCnt_q <= retiredCnt_q + 32'd1;
            if (illegal_q) illegalCnt_q <= illegalCnt_q + 16'd1;
        end
    end

    assign retired_cnt = retiredCnt_q;
    assign illegal_cnt = illegalCnt_q;
`else
    // Counter feature not built: no extra ports or state.
`endif

endmodule

// File: tb/tb_exec_sequencer.sv
// tb_exec_sequencer: self-checking bench for exec_sequencer. Directed cases
// from the test plan, then randomized instructions with random flush
// placement, all checked against an arithmetic reference model of the
// register file. Define EXEC_SEQ_PERF_CNT_EN to also check the counters.
module tb_exec_sequencer;

    logic        clk = 1'b0;
    logic        arst;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic        flush;
    logic        wb_valid;
    logic [2:0]  wb_addr;
    logic [15:0] wb_data;
    logic        illegal;
    logic [2:0]  dbg_addr;
    logic [15:0] dbg_data;
`ifdef EXEC_SEQ_PERF_CNT_EN
    logic [31:0] retired_cnt;
    logic [15:0] illegal_cnt;
`endif

    int nVectors = 0;
    int nFail    = 0;
    int refRf [8];
    int expRetired = 0;
    int expIllegal = 0;

    exec_sequencer dut (
        .clk         (clk),
        .arst        (arst),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .flush       (flush),
        .wb_valid    (wb_valid),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .illegal     (illegal),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data)
`ifdef EXEC_SEQ_PERF_CNT_EN
        ,
        .retired_cnt (retired_cnt),
        .illegal_cnt (illegal_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nVectors++;
        if (obs !== exp) begin
            nFail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bit refLegal(input int op);
        return op inside {1, 3, 11, 5, 13, 15, 7, 6, 4, 14, 12};
    endfunction

    // Reference ALU written as plain integer arithmetic on 0..65535 values.
    function automatic int refResult(input int op, input int a, input int b, input int imm);
        longint r;
        case (op)
            1:  r = (a + imm) % 65536;
            3:  r = (a + b) % 65536;
            11: r = (a - b + 65536) % 65536;
            5:  r = a & b;
            13: r = a | b;
            15: r = a ^ b;
            7:  r = 65535 - a;
            6:  r = (b >= 16)   ? 0 : (longint'(a) * (64'd1 << b)) % 65536;
            4:  r = (b >= 16)   ? 0 : a / (1 << b);
            14: r = (imm >= 16) ? 0 : (longint'(a) * (64'd1 << imm)) % 65536;
            12: r = (imm >= 16) ? 0 : a / (1 << imm);
            default: r = 0;
        endcase
        return int'(r);
    endfunction

    function automatic logic [15:0] mk(input logic [3:0] op, input logic [2:0] rd,
                                       input logic [2:0] rs1, input logic [5:0] lo);
        return {op, rd, rs1, lo};
    endfunction

    task automatic checkReg(input int r);
        dbg_addr = 3'(r);
        #1;
        checkOutput($sformatf("dbg_r%0d", r), dbg_data, refRf[r]);
    endtask

    // Runs one instruction through the handshake and checks every cycle.
    // flushStage: 0 none, 1 flush in READ, 2 in EXEC, 3 in WB (ignored by DUT).
    task automatic applyStimulus(input logic [15:0] ins, input int flushStage);
        int op, rd, rs1, rs2, imm, exp;
        op  = int'(ins[15:12]);
        rd  = int'(ins[11:9]);
        rs1 = int'(ins[8:6]);
        rs2 = int'(ins[5:3]);
        imm = int'(ins[5:0]);

        @(negedge clk);
        flush = 1'b0; instr = ins; instr_valid = 1'b1;
        #1;
        checkOutput("ready_idle", instr_ready, 1);
        checkOutput("wbv_idle", wb_valid, 0);

        @(negedge clk);
        instr_valid = 1'b0; instr = 16'($urandom);
        #1;
        checkOutput("ready_read", instr_ready, 0);
        checkOutput("illegal_read", illegal, 32'(!refLegal(op)));
        checkOutput("wbv_read", wb_valid, 0);
        if (!refLegal(op)) begin
            expIllegal++;
            @(negedge clk); #1;
            checkOutput("ready_after_illegal", instr_ready, 1);
            checkOutput("illegal_pulse_end", illegal, 0);
            checkOutput("wbv_after_illegal", wb_valid, 0);
            return;
        end
        if (flushStage == 1) begin
            flush = 1'b1;
            @(negedge clk); flush = 1'b0; #1;
            checkOutput("ready_flush_read", instr_ready, 1);
            checkOutput("wbv_flush_read", wb_valid, 0);
            checkReg(rd);
            return;
        end

        @(negedge clk); #1;
        checkOutput("ready_exec", instr_ready, 0);
        checkOutput("wbv_exec", wb_valid, 0);
        checkOutput("illegal_exec", illegal, 0);
        if (flushStage == 2) begin
            flush = 1'b1;
            @(negedge clk); flush = 1'b0; #1;
            checkOutput("ready_flush_exec", instr_ready, 1);
            checkOutput("wbv_flush_exec", wb_valid, 0);
            checkReg(rd);
            return;
        end

        exp = refResult(op, refRf[rs1], refRf[rs2], imm);
        @(negedge clk);
        if (flushStage == 3) flush = 1'b1;
        #1;
        checkOutput("wbv_wb", wb_valid, 1);
        checkOutput("wb_addr", wb_addr, rd);
        checkOutput("wb_data", wb_data, exp);
        checkOutput("ready_wb", instr_ready, 0);

        @(negedge clk); flush = 1'b0; #1;
        refRf[rd] = exp;
        expRetired++;
        checkOutput("ready_after_wb", instr_ready, 1);
        checkOutput("wbv_after_wb", wb_valid, 0);
        checkReg(rd);
    endtask

    initial begin
        logic [15:0] rnd;
        int          fs;

        arst = 1'b1; instr_valid = 1'b0; instr = '0; flush = 1'b0; dbg_addr = '0;
        for (int i = 0; i < 8; i++) refRf[i] = 0;
        #12;
        @(negedge clk); arst = 1'b0; #1;

        $display("[TB] reset state");
        for (int i = 0; i < 8; i++) checkReg(i);
        checkOutput("reset_ready", instr_ready, 1);
        checkOutput("reset_wbv", wb_valid, 0);
        checkOutput("reset_wb_addr", wb_addr, 0);
        checkOutput("reset_wb_data", wb_data, 0);
        checkOutput("reset_illegal", illegal, 0);

        $display("[TB] directed instructions");
        applyStimulus(mk(4'b0001, 3'd1, 3'd0, 6'h3F), 0);          // ADDI r1,r0,#3F
        applyStimulus(mk(4'b0001, 3'd2, 3'd0, 6'd1), 0);           // ADDI r2,r0,#1
        applyStimulus(mk(4'b1011, 3'd3, 3'd2, {3'd1, 3'd0}), 0);   // SUB r3,r2,r1
        applyStimulus(mk(4'b1110, 3'd4, 3'd1, 6'd16), 0);          // SLLI r4,r1,#16
        applyStimulus(mk(4'b0001, 3'd2, 3'd0, 6'd4), 0);           // ADDI r2,r0,#4
        applyStimulus(mk(4'b0110, 3'd5, 3'd1, {3'd2, 3'd0}), 0);   // SLL r5,r1,r2
        applyStimulus(mk(4'b0111, 3'd6, 3'd0, 6'd0), 0);           // NOT r6,r0
        applyStimulus(mk(4'b0010, 3'd7, 3'd0, 6'd0), 0);           // LOAD -> illegal
        applyStimulus(mk(4'b0001, 3'd7, 3'd0, 6'd5), 2);           // flush in EXEC
        applyStimulus(mk(4'b0001, 3'd7, 3'd0, 6'd9), 3);           // flush in WB
        applyStimulus(mk(4'b0011, 3'd1, 3'd1, {3'd1, 3'd0}), 1);   // flush in READ

        // Flush while idle must block the handshake for that cycle.
        @(negedge clk);
        flush = 1'b1; instr_valid = 1'b1; instr = mk(4'b0001, 3'd0, 3'd0, 6'd7);
        #1;
        checkOutput("ready_idle_flush", instr_ready, 0);
        @(negedge clk); flush = 1'b0; instr_valid = 1'b0; #1;
        checkOutput("ready_idle_noaccept", instr_ready, 1);
        checkReg(0);

        $display("[TB] randomized instructions");
        for (int n = 0; n < 150; n++) begin
            rnd = 16'($urandom);
            fs  = int'($urandom_range(0, 7));
            applyStimulus(rnd, (fs > 3) ? 0 : fs);
        end
        for (int i = 0; i < 8; i++) checkReg(i);

        $display("[TB] asynchronous reset mid-EXEC");
        for (int i = 1; i < 8; i++) refRf[i] = (refRf[i] == 0) ? 0 : refRf[i];
        @(negedge clk);
        instr = mk(4'b0011, 3'd3, 3'd1, {3'd2, 3'd0}); instr_valid = 1'b1;
        @(negedge clk); instr_valid = 1'b0;
        @(negedge clk);
        arst = 1'b1; #1;
        for (int i = 0; i < 8; i++) refRf[i] = 0;
        for (int i = 0; i < 8; i++) checkReg(i);
        checkOutput("ready_after_arst", instr_ready, 1);
        checkOutput("wbv_after_arst", wb_valid, 0);
        @(negedge clk); arst = 1'b0; #1;
        @(negedge clk); #1;
        checkOutput("wbv_post_arst", wb_valid, 0);
        expRetired = 0;
        expIllegal = 0;

        applyStimulus(mk(4'b0001, 3'd1, 3'd0, 6'd10), 0);
        applyStimulus(mk(4'b0011, 3'd2, 3'd1, {3'd1, 3'd0}), 0);
        applyStimulus(mk(4'b1010, 3'd3, 3'd1, 6'd0), 0);           // STORE -> illegal
        applyStimulus(mk(4'b1111, 3'd3, 3'd2, {3'd1, 3'd0}), 0);
`ifdef EXEC_SEQ_PERF_CNT_EN
        checkOutput("retired_cnt", retired_cnt, expRetired);
        checkOutput("illegal_cnt", illegal_cnt, expIllegal);
`endif
        for (int i = 0; i < 8; i++) checkReg(i);

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nFail);
        $finish;
    end

endmodule

// File: doc/exec_sequencer.md
Name: exec_sequencer

Overview:
Multi-cycle instruction sequencer that owns the 8-entry x 16-bit architectural register file and the 16-bit ALU datapath. It accepts one 16-bit instruction at a time over a valid/ready handshake and walks it through READ, EXEC and WB states. It writes the result back and pulses a writeback indication. It sits between the instruction source and the register file / ALU.

Parameters:
DATA_W, 16, datapath and register width
NUM_REGS, 8, register count; register address width is 3 bits

Ports:
clk  input  1  clock, rising edge
arst  input  1  asynchronous active-high reset
instr_valid  input  1  instruction offered
instr_ready  output  1  sequencer can accept; high only in IDLE
instr  input  16  [15:12] opcode, [11:9] rd, [8:6] rs1, [5:3] rs2, [5:0] imm (zero-extended)
flush  input  1  synchronous abort of the in-flight instruction
wb_valid  output  1  one-cycle pulse when the register file is written
wb_addr  output  3  destination register written
wb_data  output  16  value written
illegal  output  1  one-cycle pulse on an unsupported opcode
dbg_addr  input  3  debug read address
dbg_data  output  16  combinational read of rf[dbg_addr]

Behaviour:
- Reset (arst high, async): state=IDLE; all registers, IR, operand and result latches = 0; wb_valid=0, wb_addr=0, wb_data=0, illegal=0. Reset mid-instruction discards it with no writeback.
- IDLE: instr_ready=1. A transfer occurs when instr_valid && instr_ready; instr is latched into IR and the state moves to READ. No transfer leaves the state in IDLE.
- READ: opA=rf[rs1], opB=rf[rs2].
  - Legal opcode: go to EXEC.
  - Illegal opcode: illegal=1 for this cycle, go to IDLE, no writeback.
- EXEC: result register <= ALU(opcode, opA, opB, imm); go to WB.
- WB: rf[rd] <= result; wb_valid=1, wb_addr=rd, wb_data=result; go to IDLE.
- Outputs are registered. wb_valid and illegal are low outside their single cycle.
- Latency: accept at edge N; WB cycle is N+3; the next accept is at edge N+4. Throughput is 1 instruction per 4 cycles.
- Opcodes:
  - 0001 ADDI: rs1+imm
  - 0011 ADD; 1011 SUB
  - 0101 AND; 1101 OR; 1111 XOR
  - 0111 NOT: ~rs1
  - 0110 SLL; 0100 SRL: shift by opB
  - 1110 SLLI; 1100 SRLI: shift by imm
  - All other opcodes (including 0010 LOAD and 1010 STORE) are illegal.
- Arithmetic: modulo 2^16, carry/borrow dropped. Shifts are logical. A shift amount >= 16 yields 0.
- rd=rs1 or rd=rs2 is legal. Operands are captured in READ, so the old value is used.
- flush:
  - In READ or EXEC: next state IDLE, no writeback, no illegal pulse.
  - In WB: ignored; the write commits.
  - In IDLE: blocks acceptance that cycle (instr_ready=0 while flush=1).
- dbg_data reflects register writes the cycle after WB.

Optional Feature:
Macro EXEC_SEQ_PERF_CNT_EN.
- Defined: adds output ports retired_cnt (32 bits, increments on every wb_valid) and illegal_cnt (16 bits, increments on every illegal pulse). Both are reset to 0 by arst and wrap at their maximum value.
- Undefined: neither the ports nor the counters exist. All other behaviour is identical.

Decomposition:
- Package exec_pkg:
  - opcode_e enum with the 11 legal opcodes
  - seq_state_e enum {IDLE, READ, EXEC, WB}
  - instruction field bit-position localparams
  - DATA_W and REG_ADDR_W constants
- Sub-module exec_alu: purely combinational 16-bit ALU (opcode, opA, opB, imm -> result). The register file and FSM remain in exec_sequencer.

Test Plan:
- Reset, then dbg-read r0..r7 -> all 0x0000; instr_ready=1; wb_valid=0.
- ADDI r1,r0,#0x3F accepted at cycle 0 -> wb_valid at cycle 3 with wb_addr=1, wb_data=0x003F; instr_ready low in cycles 1-3.
- With r1=0x003F: ADDI r2,r0,#1, then SUB r3,r2,r1 -> wb_data=0xFFC2 (wraparound).
- With r1=0x003F: SLLI r4,r1,#16 -> 0x0000; SLL r5,r1,r2 with r2=4 -> 0x03F0; NOT r6,r0 -> 0xFFFF.
- Opcode 0010 -> illegal pulse at cycle 1, no wb_valid, instr_ready=1 at cycle 2. Flush asserted in EXEC -> no wb_valid, target register unchanged.
- arst asserted mid-EXEC -> registers cleared immediately, state IDLE. With EXEC_SEQ_PERF_CNT_EN defined: 3 legal + 1 illegal instruction -> retired_cnt=3, illegal_cnt=1.
